clock_ctrl: RTL and testbench

CLOCK_CTRL -- requirements
Module: clock_ctrl

---
 rtl/clock_ctrl.sv | 116 +++++++++++
 tb/tb_clock_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_ctrl.sv
// rtl/clock_ctrl.sv - run/set mode controller for an HH:MM:SS clock
// Turns the 1 Hz tick and two debounced keys into registered counter enable pulses.
module clock_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       key_mode,
    input  logic       key_inc,
    input  logic       sec_tc,
    input  logic       min_tc,
    output logic       en_sec,
    output logic       en_min,
    output logic       en_hour,
    output logic       sec_clr,
    output logic [1:0] mode,
    output logic       blink
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_SET_HR  = 2'b01,
        ST_SET_MIN = 2'b10,
        ST_BAD     = 2'b11
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_mode_prev;
    logic       r_inc_prev;
    logic [1:0] r_hold;
    logic [1:0] w_hold_nxt;
    logic       w_mode_press;
    logic       w_inc_press;
    logic       w_repeat;
    logic       w_inc_pulse;
    logic       w_en_sec_nxt;
    logic       w_en_min_nxt;
    logic       w_en_hour_nxt;
    logic       w_sec_clr_nxt;
    logic       w_blink_nxt;

    assign w_mode_press = key_mode & ~r_mode_prev;
    assign w_inc_press  = key_inc & ~r_inc_prev;
    // a press and a repeat tick landing together still give a single pulse
    assign w_repeat     = tick & key_inc & (r_hold == 2'd2);
    assign w_inc_pulse  = w_inc_press | w_repeat;
    assign mode         = r_state;

    always_comb begin
        w_state_nxt   = r_state;
        w_en_sec_nxt  = 1'b0;
        w_en_min_nxt  = 1'b0;
        w_en_hour_nxt = 1'b0;
        w_sec_clr_nxt = 1'b0;
        w_hold_nxt    = 2'd0;
        w_blink_nxt   = blink;

        case (r_state)
            ST_RUN: begin
                if (tick) begin
                    w_en_sec_nxt  = 1'b1;
                    w_en_min_nxt  = sec_tc;
                    w_en_hour_nxt = sec_tc & min_tc;
                end
                if (w_mode_press) w_state_nxt = ST_SET_HR;
            end
            ST_SET_HR: begin
                if (w_mode_press) w_state_nxt = ST_SET_MIN;
                else              w_en_hour_nxt = w_inc_pulse;
            end
            ST_SET_MIN: begin
                if (w_mode_press) begin
                    w_state_nxt   = ST_RUN;
                    w_sec_clr_nxt = 1'b1;
                end else begin
                    w_en_min_nxt  = w_inc_pulse;
                end
            end
            default: w_state_nxt = ST_RUN;
        endcase

        if (w_state_nxt != r_state || w_state_nxt == ST_RUN) w_blink_nxt = 1'b1;
        else if (tick)                                         w_blink_nxt = ~blink;

        // hold counter only lives while key_inc stays down inside one set state
        if (w_state_nxt == r_state && r_state != ST_RUN && key_inc) begin
            if (tick && r_hold != 2'd2) w_hold_nxt = r_hold + 2'd1;
            else                        w_hold_nxt = r_hold;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_RUN;
            r_mode_prev <= 1'b1;
            r_inc_prev  <= 1'b1;
            r_hold      <= 2'd0;
            en_sec      <= 1'b0;
            en_min      <= 1'b0;
            en_hour     <= 1'b0;
            sec_clr     <= 1'b0;
            blink       <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_mode_prev <= key_mode;
            r_inc_prev  <= key_inc;
            r_hold      <= w_hold_nxt;
            en_sec      <= w_en_sec_nxt;
            en_min      <= w_en_min_nxt;
            en_hour     <= w_en_hour_nxt;
            sec_clr     <= w_sec_clr_nxt;
            blink       <= w_blink_nxt;
        end
    end

endmodule

// File: tb/tb_clock_ctrl.sv
// tb/tb_clock_ctrl.sv - self-checking bench for clock_ctrl
// Directed scenarios followed by randomized key/tick traffic against a reference model.
module tb_clock_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick = 1'b0;
    logic       key_mode = 1'b0;
    logic       key_inc = 1'b0;
    logic       sec_tc = 1'b0;
    logic       min_tc = 1'b0;
    logic       en_sec;
    logic       en_min;
    logic       en_hour;
    logic       sec_clr;
    logic [1:0] mode;
    logic       blink;

    int n_chk = 0;
    int n_pass = 0;

    // reference model state: mode index into RUN, SET_HR, SET_MIN
    int m_mode;
    int m_hold;
    bit m_blink;
    bit m_kmp;
    bit m_kip;
    bit e_sec, e_min, e_hr, e_clr;

    int n_sec, n_min, n_hr, n_clr, n_tog;
    bit last_blink;
    bit cur_km, cur_ki;

    clock_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .key_mode (key_mode),
        .key_inc  (key_inc),
        .sec_tc   (sec_tc),
        .min_tc   (min_tc),
        .en_sec   (en_sec),
        .en_min   (en_min),
        .en_hour  (en_hour),
        .sec_clr  (sec_clr),
        .mode     (mode),
        .blink    (blink)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    endtask

    task automatic clr_cnt();
        n_sec = 0; n_min = 0; n_hr = 0; n_clr = 0; n_tog = 0;
    endtask

    task automatic model(input bit t, input bit km, input bit ki, input bit st, input bit mt);
        bit mp, ip, rep;
        int nm;
        mp = km && !m_kmp;
        ip = ki && !m_kip;
        e_sec = 0; e_min = 0; e_hr = 0; e_clr = 0;
        nm = m_mode;
        if (m_mode == 0) begin
            if (t) begin
                e_sec = 1;
                e_min = st;
                e_hr  = st && mt;
            end
            if (mp) nm = 1;
        end else if (mp) begin
            nm = (m_mode + 1) % 3;
            e_clr = (m_mode == 2);
        end else begin
            rep = t && ki && (m_hold >= 2);
            if (ip || rep) begin
                if (m_mode == 1) e_hr = 1;
                else             e_min = 1;
            end
        end
        if (nm != m_mode || nm == 0 || !ki) m_hold = 0;
        else if (t)                         m_hold = (m_hold < 2) ? m_hold + 1 : 2;
        if (nm == 0 || nm != m_mode) m_blink = 1;
        else if (t)                  m_blink = !m_blink;
        m_mode = nm;
        m_kmp  = km;
        m_kip  = ki;
    endtask

    task automatic step(input bit t, input bit km, input bit ki, input bit st, input bit mt);
        tick = t; key_mode = km; key_inc = ki; sec_tc = st; min_tc = mt;
        model(t, km, ki, st, mt);
        @(posedge clk);
        #1;
        chk("en_sec", en_sec, e_sec);
        chk("en_min", en_min, e_min);
        chk("en_hour", en_hour, e_hr);
        chk("sec_clr", sec_clr, e_clr);
        chk("mode", mode, m_mode[1:0]);
        chk("blink", blink, m_blink);
        n_sec += int'(en_sec);
        n_min += int'(en_min);
        n_hr  += int'(en_hour);
        n_clr += int'(sec_clr);
        if (blink != last_blink) n_tog++;
        last_blink = blink;
        cur_km = km;
        cur_ki = ki;
    endtask

    task automatic rst_outs(input string tag);
        chk({tag, "_mode"}, mode, 0);
        chk({tag, "_en"}, {en_sec, en_min, en_hour}, 0);
        chk({tag, "_clr"}, sec_clr, 0);
        chk({tag, "_blink"}, blink, 1);
    endtask

    task automatic do_reset(input bit km, input bit ki);
        tick = 0; key_mode = km; key_inc = ki;
        rst = 1;
        #1;
        rst_outs("rst_async");
        @(posedge clk);
        #1;
        rst_outs("rst_held");
        rst = 0;
        m_mode = 0; m_hold = 0; m_blink = 1; m_kmp = 1; m_kip = 1;
        last_blink = 1;
        cur_km = km;
        cur_ki = ki;
    endtask

    task automatic press_mode();
        step(0, 1, cur_ki, 0, 0);
        step(0, 0, cur_ki, 0, 0);
    endtask

    initial begin
        bit t, km, ki, st, mt;
        clr_cnt();
        #3;
        do_reset(0, 0);
        step(0, 0, 0, 0, 0);

        // full carry tick, then a plain tick
        clr_cnt();
        step(1, 0, 0, 1, 1);
        step(0, 0, 0, 1, 1);
        chk("carry_sec", n_sec, 1);
        chk("carry_min", n_min, 1);
        chk("carry_hr", n_hr, 1);
        clr_cnt();
        step(1, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        chk("plain_sec", n_sec, 1);
        chk("plain_min", n_min, 0);
        chk("plain_hr", n_hr, 0);

        // mode cycling, sec_clr only on SET_MIN -> RUN
        clr_cnt();
        press_mode();
        chk("cyc_m1", mode, 1);
        press_mode();
        chk("cyc_m2", mode, 2);
        chk("cyc_noclr", n_clr, 0);
        press_mode();
        chk("cyc_m0", mode, 0);
        chk("cyc_clr", n_clr, 1);

        // SET_MIN manual increment with min_tc high, then frozen ticks
        press_mode();
        press_mode();
        clr_cnt();
        step(0, 0, 1, 0, 1);
        step(0, 0, 0, 0, 1);
        chk("setmin_min", n_min, 1);
        chk("setmin_hr", n_hr, 0);
        clr_cnt();
        for (int k = 0; k < 10; k++) begin
            step(1, 0, 0, 1, 1);
            step(0, 0, 0, 1, 1);
        end
        chk("frozen_en", n_sec + n_min + n_hr, 0);
        chk("frozen_tog", n_tog, 10);
        press_mode();

        // SET_HR auto-repeat: press + 5 held ticks -> 4 pulses
        press_mode();
        clr_cnt();
        step(0, 0, 1, 0, 0);
        for (int k = 0; k < 5; k++) begin
            step(1, 0, 1, 0, 0);
            step(0, 0, 1, 0, 0);
            step(0, 0, 1, 0, 0);
        end
        step(0, 0, 0, 0, 0);
        chk("rep_hr", n_hr, 4);
        chk("rep_min", n_min, 0);

        // coincident mode and inc press in SET_HR
        clr_cnt();
        step(0, 1, 1, 0, 0);
        chk("both_mode", mode, 2);
        step(0, 0, 0, 0, 0);
        chk("both_hr", n_hr, 0);

        // reset during SET_MIN with inc held, release with keys held
        step(0, 0, 1, 0, 0);
        step(1, 0, 1, 0, 0);
        clr_cnt();
        do_reset(1, 1);
        for (int k = 0; k < 3; k++) step(0, 1, 1, 0, 0);
        chk("rel_mode", mode, 0);
        chk("rel_pulses", n_sec + n_min + n_hr + n_clr, 0);
        step(0, 0, 0, 0, 0);

        // randomized traffic
        km = cur_km;
        ki = cur_ki;
        for (int i = 0; i < 4000; i++) begin
            t  = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 19) == 0) km = ~km;
            if ($urandom_range(0, 24) == 0) ki = ~ki;
            if ($urandom_range(0, 59) == 0) begin
                km = 1;
                ki = 1;
            end
            st = ($urandom_range(0, 2) == 0);
            mt = ($urandom_range(0, 1) == 0);
            if ($urandom_range(0, 399) == 0) do_reset(km, ki);
            else                             step(t, km, ki, st, mt);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
